// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI round-robin arbiter.
package spi_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_TIMEOUT = 256;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT,
    DONE
  } arb_state_t;

  // Width of an index into n requesters; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester-side handshake plus SPI master hookup for spi_arbiter.
interface spi_arbiter_if
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic                      spi_tx_en;
  logic [DATA_W-1:0]         spi_din;
  logic                      spi_done;
  logic                      spi_cs;
  logic [NUM_REQ-1:0]        cs_n;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, spi_done, spi_cs,
    output req_ready, req_done, req_err, spi_tx_en, spi_din, cs_n
  );

  // Requesters and SPI master side.
  modport master (
    output req_valid, req_data, spi_done, spi_cs,
    input  req_ready, req_done, req_err, spi_tx_en, spi_din, cs_n
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_REQ
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [idx_w(N)-1:0]   grant,
  output logic                  any_req
);

  localparam int unsigned IDX_W = idx_w(N);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[IDX_W'(idx)]) begin
        grant = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters,
// with per-transfer timeout and per-slave chip-select steering.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic         clk,
  input logic         rst,
  spi_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  // Last WAIT cycle: its increment would bring the counter to TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               tx_en_q, tx_en_d;

  logic [IDX_W-1:0]   win;
  logic               any_req;
  logic [NUM_REQ-1:0] g_onehot;
  logic [NUM_REQ-1:0] cs_n_c;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .grant   (win),
    .any_req (any_req)
  );

  assign g_onehot = NUM_REQ'(1) << g_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      din_q   <= '0;
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      tx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tx_en_q <= tx_en_d;
    end
  end

  // Pulses are decoded on the transition so they appear in the target state.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    ready_d = '0;
    done_d  = '0;
    err_d   = '0;
    tx_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          g_d     = win;
          ready_d = NUM_REQ'(1) << win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        din_d   = bus.req_data[32'(g_q) * DATA_W +: DATA_W];
        tx_en_d = 1'b1;
        state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (bus.spi_done) begin
          done_d  = g_onehot;
          state_d = DONE;
        end else if (cnt_q == CNT_FINAL) begin
          err_d   = g_onehot;
          ptr_d   = g_q;
          state_d = IDLE;
        end
      end
      DONE: begin
        ptr_d   = g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Chip select passes through only to the granted slave while it owns the bus.
  always_comb begin
    cs_n_c = '1;
    if (state_q inside {START, WAIT, DONE}) begin
      cs_n_c[g_q] = bus.spi_cs;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.req_done  = done_q;
  assign bus.req_err   = err_q;
  assign bus.spi_tx_en = tx_en_q;
  assign bus.spi_din   = din_q;
  assign bus.cs_n      = cs_n_c;

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters/slaves; DATA_W, default 8, transfer width; TIMEOUT, default 256, max cycles waiting for spi_done.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  NUM_REQ  per-requester transfer request; held until req_ready.
REQ-005 req_data  in  NUM_REQ*DATA_W  per-requester payload, slice i = bits [i*DATA_W +: DATA_W]; held with req_valid.
REQ-006 req_ready  out  NUM_REQ  one-hot one-cycle pulse: payload of requester i captured.
REQ-007 req_done  out  NUM_REQ  one-hot one-cycle pulse: requester i transfer completed.
REQ-008 req_err  out  NUM_REQ  one-hot one-cycle pulse: requester i transfer timed out.
REQ-009 spi_tx_en  out  1  one-cycle start strobe to SPI master.
REQ-010 spi_din  out  DATA_W  byte to SPI master; stable from spi_tx_en until end of WAIT.
REQ-011 spi_done  in  1  one-cycle completion pulse from SPI master.
REQ-012 spi_cs  in  1  chip select from SPI master (active-low).
REQ-013 cs_n  out  NUM_REQ  per-slave chip select, active-low.

Function
REQ-014 FSM SHALL have states IDLE, GRANT, START, WAIT, DONE.
REQ-015 IDLE: if any req_valid, SHALL select winner g round-robin, searching from index ptr+1 upward with wrap, register g, go GRANT; else stay.
REQ-016 GRANT: SHALL capture req_data slice g into spi_din, assert req_ready[g] this cycle only, go START.
REQ-017 START: SHALL assert spi_tx_en this cycle only, clear timeout counter, go WAIT.
REQ-018 WAIT: counter increments each cycle; spi_done=1 -> DONE; counter reaching TIMEOUT-1 without spi_done -> assert req_err[g] one cycle, ptr<=g, go IDLE.
REQ-019 DONE: SHALL assert req_done[g] this cycle only, ptr<=g, go IDLE.
REQ-020 Latency: req_valid sampled in IDLE at cycle N -> req_ready N+1, spi_tx_en N+2, req_done one cycle after spi_done.
REQ-021 cs_n[g] SHALL follow spi_cs in states START, WAIT, DONE; all other cs_n bits and all bits in IDLE/GRANT SHALL be 1.
REQ-022 spi_done and timeout in the same WAIT cycle: spi_done wins, no req_err.
REQ-023 spi_done outside WAIT SHALL be ignored.
REQ-024 req_valid deasserted before IDLE sampling SHALL not be granted; requests arriving outside IDLE wait for next IDLE.
REQ-025 Single requester continuously valid SHALL be re-granted each round; two or more SHALL alternate strictly by round-robin order.
REQ-026 Timeout counter width SHALL be $clog2(TIMEOUT+1); it SHALL not wrap.
REQ-027 At most one bit of req_ready, req_done, req_err SHALL be set in any cycle.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, ptr=NUM_REQ-1 (requester 0 highest first priority), counter=0, spi_din=0.
REQ-029 Reset values: req_ready=0, req_done=0, req_err=0, spi_tx_en=0, cs_n all 1.
REQ-030 Reset mid-transfer SHALL abandon it with no req_done/req_err pulse, cs_n all 1 from the next cycle.

Structure
REQ-031 Package spi_pkg SHALL hold arb_state_t enum (IDLE..DONE) and default parameter constants.
REQ-032 Round-robin winner selection SHALL be sub-module rr_arbiter (inputs req, ptr; outputs grant index, any_req), purely combinational.
REQ-033 All other logic SHALL reside in spi_arbiter.

Verification
REQ-034 Reset: rst high 2 cycles with req_valid=4'b1111 -> all pulses 0, cs_n=4'b1111, no spi_tx_en.
REQ-035 Single request: req_valid[2]=1, slice 2=8'hA3 at N -> req_ready[2] N+1, spi_tx_en N+2 with spi_din=8'hA3, spi_done at N+10 -> req_done[2] at N+11.
REQ-036 Fairness: req_valid=4'b1111 held, spi_done 5 cycles after each tx_en -> grant order 0,1,2,3,0.
REQ-037 Timeout: TIMEOUT=16, no spi_done -> req_err[g] 16 cycles after spi_tx_en, then IDLE, next requester granted.
REQ-038 Boundaries: spi_done coincident with final timeout cycle -> req_done only; rst during WAIT -> cs_n=4'b1111 next cycle, no done/err.
